// File: rtl/cpu_pkg.sv
// cpu_pkg: shared decode constants and the ID/EX pipeline register layout.
// Contents: DATA_WIDTH default operand width, INST_ADD internal opcode,
// one-hot inst_type codes {U,B,S,I,R} = bits 4..0, RV opcode/funct fields,
// and the packed id_ex_t struct carried from decode to execute.
package cpu_pkg;

   localparam int DATA_WIDTH = 64;

   localparam logic [7:0] INST_ADD  = 8'h11;
   localparam logic [7:0] INST_NONE = 8'h00;

   localparam logic [4:0] TYPE_NONE = 5'b00000;
   localparam logic [4:0] TYPE_R    = 5'b00001;
   localparam logic [4:0] TYPE_I    = 5'b00010;
   localparam logic [4:0] TYPE_S    = 5'b00100;
   localparam logic [4:0] TYPE_B    = 5'b01000;
   localparam logic [4:0] TYPE_U    = 5'b10000;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [2:0] F3_ADD     = 3'b000;
   localparam logic [6:0] F7_ADD     = 7'b0000000;

   typedef struct packed {
      logic [4:0]            inst_type;
      logic [7:0]            opcode;
      logic [DATA_WIDTH-1:0] op1;
      logic [DATA_WIDTH-1:0] op2;
      logic [4:0]            rd_addr;
      logic                  rd_we;
      logic                  illegal;
   } id_ex_t;

endpackage

// File: rtl/id_fwd_mux.sv
// id_fwd_mux: hazard match and operand selection for one source register.
// Ports: src_addr/src_en (source register and whether it is read),
// ex_* (instruction held in ID/EX), wb_* (write happening this cycle),
// rf_data (regfile read data), data (selected operand), match (EX or WB hit).
// Build option ID_BYPASS_EN: when defined, data is forwarded EX > WB > regfile;
// otherwise data always comes from the regfile and match is used to stall.
module id_fwd_mux import cpu_pkg::*; #(
   parameter int XLEN = DATA_WIDTH
) (
   input  logic [4:0]      src_addr,
   input  logic            src_en,
   input  logic            ex_valid,
   input  logic            ex_rd_we,
   input  logic [4:0]      ex_rd_addr,
   input  logic [XLEN-1:0] ex_rd_data,
   input  logic            wb_rd_we,
   input  logic [4:0]      wb_rd_addr,
   input  logic [XLEN-1:0] wb_rd_data,
   input  logic [XLEN-1:0] rf_data,
   output logic [XLEN-1:0] data,
   output logic            match
);

   logic ex_match_s;
   logic wb_match_s;

   // x0 is hard-wired zero, so it never matches a producer.
   assign ex_match_s = src_en && (src_addr != 5'd0) && ex_valid && ex_rd_we
                       && (src_addr == ex_rd_addr);
   assign wb_match_s = src_en && (src_addr != 5'd0) && wb_rd_we
                       && (src_addr == wb_rd_addr);
   assign match      = ex_match_s || wb_match_s;

`ifdef ID_BYPASS_EN
   // Operand select: newest producer wins.
   always_comb begin
      if (src_addr == 5'd0) begin
         data = {XLEN{1'b0}};
      end else if (ex_match_s) begin
         data = ex_rd_data;
      end else if (wb_match_s) begin
         data = wb_rd_data;
      end else begin
         data = rf_data;
      end
   end
`else
   logic unused_fwd_s;
   assign unused_fwd_s = ^{ex_rd_data, wb_rd_data};

   // Operand select: regfile only, hazards are resolved by stalling.
   always_comb begin
      if (src_addr == 5'd0) begin
         data = {XLEN{1'b0}};
      end else begin
         data = rf_data;
      end
   end
`endif

endmodule

// File: rtl/id_stage.sv
// id_stage: decode stage. Decodes ADD/ADDI, reads the regfile, resolves RAW
// hazards against EX and WB, and holds the result in a registered ID/EX stage.
// Ports: clk, rst_n (async active-low); inst_valid/inst_ready/inst (fetch);
// flush; rs1/rs2_addr and rs1/rs2_data (regfile); ex_rd_data (EX result);
// wb_rd_we/addr/data (writeback); ex_valid/ex_ready (execute handshake);
// inst_type, inst_opcode, op1, op2, rd_addr, rd_we, ex_illegal (ID/EX fields).
// Build option ID_BYPASS_EN: forwarding instead of stalling on hazards.
module id_stage import cpu_pkg::*; #(
   parameter int XLEN = DATA_WIDTH
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            inst_valid,
   output logic            inst_ready,
   input  logic [31:0]     inst,
   input  logic            flush,
   output logic [4:0]      rs1_addr,
   output logic [4:0]      rs2_addr,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] rs2_data,
   input  logic [XLEN-1:0] ex_rd_data,
   input  logic            wb_rd_we,
   input  logic [4:0]      wb_rd_addr,
   input  logic [XLEN-1:0] wb_rd_data,
   output logic            ex_valid,
   input  logic            ex_ready,
   output logic [4:0]      inst_type,
   output logic [7:0]      inst_opcode,
   output logic [XLEN-1:0] op1,
   output logic [XLEN-1:0] op2,
   output logic [4:0]      rd_addr,
   output logic            rd_we,
   output logic            ex_illegal
);

   id_ex_t          id_ex_r;
   id_ex_t          id_ex_s;
   logic            ex_valid_r;
   logic            is_add_s;
   logic            is_addi_s;
   logic            legal_s;
   logic [XLEN-1:0] imm_s;
   logic [XLEN-1:0] rs1_op_s;
   logic [XLEN-1:0] rs2_op_s;
   logic            rs1_match_s;
   logic            rs2_match_s;
   logic            stall_s;
   logic            accept_s;

   assign rs1_addr  = inst[19:15];
   assign rs2_addr  = inst[24:20];

   assign is_add_s  = (inst[6:0] == OPC_OP) && (inst[14:12] == F3_ADD)
                      && (inst[31:25] == F7_ADD);
   assign is_addi_s = (inst[6:0] == OPC_OP_IMM) && (inst[14:12] == F3_ADD);
   assign legal_s   = is_add_s || is_addi_s;
   assign imm_s     = {{(XLEN-12){inst[31]}}, inst[31:20]};

   // rs2 is only a real source for R-type; illegal words read nothing.
   id_fwd_mux #(.XLEN(XLEN)) u_fwd_rs1 (
      .src_addr  (rs1_addr),
      .src_en    (legal_s),
      .ex_valid  (ex_valid_r),
      .ex_rd_we  (id_ex_r.rd_we),
      .ex_rd_addr(id_ex_r.rd_addr),
      .ex_rd_data(ex_rd_data),
      .wb_rd_we  (wb_rd_we),
      .wb_rd_addr(wb_rd_addr),
      .wb_rd_data(wb_rd_data),
      .rf_data   (rs1_data),
      .data      (rs1_op_s),
      .match     (rs1_match_s)
   );

   id_fwd_mux #(.XLEN(XLEN)) u_fwd_rs2 (
      .src_addr  (rs2_addr),
      .src_en    (is_add_s),
      .ex_valid  (ex_valid_r),
      .ex_rd_we  (id_ex_r.rd_we),
      .ex_rd_addr(id_ex_r.rd_addr),
      .ex_rd_data(ex_rd_data),
      .wb_rd_we  (wb_rd_we),
      .wb_rd_addr(wb_rd_addr),
      .wb_rd_data(wb_rd_data),
      .rf_data   (rs2_data),
      .data      (rs2_op_s),
      .match     (rs2_match_s)
   );

`ifdef ID_BYPASS_EN
   assign stall_s = 1'b0;
`else
   assign stall_s = rs1_match_s || rs2_match_s;
`endif

   // rst_n gates ready so fetch never sees a transfer while reset is held.
   assign inst_ready = rst_n && !flush && !stall_s && (!ex_valid_r || ex_ready);
   assign accept_s   = inst_valid && inst_ready;

   // Decode the presented instruction into the next ID/EX contents.
   always_comb begin
      id_ex_s = '0;
      if (is_add_s) begin
         id_ex_s.inst_type = TYPE_R;
         id_ex_s.opcode    = INST_ADD;
         id_ex_s.op1       = DATA_WIDTH'(rs1_op_s);
         id_ex_s.op2       = DATA_WIDTH'(rs2_op_s);
         id_ex_s.rd_addr   = inst[11:7];
         id_ex_s.rd_we     = (inst[11:7] != 5'd0);
         id_ex_s.illegal   = 1'b0;
      end else if (is_addi_s) begin
         id_ex_s.inst_type = TYPE_I;
         id_ex_s.opcode    = INST_ADD;
         id_ex_s.op1       = DATA_WIDTH'(rs1_op_s);
         id_ex_s.op2       = DATA_WIDTH'(imm_s);
         id_ex_s.rd_addr   = inst[11:7];
         id_ex_s.rd_we     = (inst[11:7] != 5'd0);
         id_ex_s.illegal   = 1'b0;
      end else begin
         id_ex_s.inst_type = TYPE_NONE;
         id_ex_s.opcode    = INST_NONE;
         id_ex_s.illegal   = 1'b1;
      end
   end

   // ID/EX register: flush beats load, load beats drain, otherwise hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid_r <= 1'b0;
         id_ex_r    <= '0;
      end else if (flush) begin
         ex_valid_r <= 1'b0;
         id_ex_r    <= '0;
      end else if (accept_s) begin
         ex_valid_r <= 1'b1;
         id_ex_r    <= id_ex_s;
      end else if (ex_ready) begin
         ex_valid_r <= 1'b0;
      end else begin
         ex_valid_r <= ex_valid_r;
      end
   end

   assign ex_valid    = ex_valid_r;
   assign inst_type   = id_ex_r.inst_type;
   assign inst_opcode = id_ex_r.opcode;
   assign op1         = id_ex_r.op1[XLEN-1:0];
   assign op2         = id_ex_r.op2[XLEN-1:0];
   assign rd_addr     = id_ex_r.rd_addr;
   assign rd_we       = id_ex_r.rd_we;
   assign ex_illegal  = id_ex_r.illegal;

endmodule

// File: doc/id_stage.md
# id_stage

Decode stage for the CPU pipeline. It accepts 32-bit RV64 instructions from fetch over a valid/ready handshake, decodes ADD and ADDI, reads the register file, and resolves RAW hazards against the in-flight EX and WB instructions. It presents operands to the execute stage through a registered ID/EX pipeline register with its own valid/ready handshake.

## Interface
- `XLEN`, default `DATA_WIDTH`: operand width.
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `inst_valid` / `inst_ready`  in / out  1  fetch handshake.
- `inst`  in  32  instruction word.
- `flush`  in  1  discards the ID/EX contents and blocks acceptance this cycle.
- `rs1_addr`, `rs2_addr`  out  5  regfile read addresses, combinational from `inst`.
- `rs1_data`, `rs2_data`  in  XLEN  regfile read data, same cycle, no internal write-through.
- `ex_rd_data`  in  XLEN  execute result for the instruction currently held in ID/EX.
- `wb_rd_we`, `wb_rd_addr`, `wb_rd_data`  in  1/5/XLEN  write occurring this cycle.
- `ex_valid` / `ex_ready`  out / in  1  execute handshake.
- `inst_type`  out  5  one-hot type, {U,B,S,I,R} = bits 4..0.
- `inst_opcode`  out  8  `INST_ADD` (8'h11), or 0 for NOP/illegal.
- `op1`, `op2`  out  XLEN  operands.
- `rd_addr`, `rd_we`  out  5/1  destination.
- `ex_illegal`  out  1  undecodable instruction flag.

## Operation
- ADD: opcode 7'b0110011, funct3 000, funct7 0. Produces type R, op1=rs1, op2=rs2.
- ADDI: opcode 7'b0010011, funct3 000. Produces type I, op1=rs1, op2=sign-extended imm[11:0] to XLEN.
- Anything else: opcode 0, type 0, rd_we=0, ex_illegal=1. The instruction still flows through as a bubble-with-flag.
- rd_we=1 only for a legal instruction with rd≠0.
- Register x0 always reads 0 and is never forwarded or stalled on.
- Hazard match: a source register (rs1; rs2 for R only) ≠0 equal to `rd_addr` while `ex_valid&&rd_we` (EX match), or equal to `wb_rd_addr` while `wb_rd_we` (WB match).
- Operand priority: EX match → `ex_rd_data`; else WB match → `wb_rd_data`; else regfile data.
- Acceptance: `inst_ready = !flush && !stall && (!ex_valid || ex_ready)`. A transfer occurs on `inst_valid && inst_ready`, which loads all ID/EX fields and sets ex_valid=1.
- ex_valid clears on `ex_ready` with no new load, or on `flush`.
- `flush` has priority over everything.
- With `ex_valid && !ex_ready`, every output holds stable.

## Timing
- Reset value of every output register: 0, with ex_valid=0. `inst_ready` is 0 during reset.
- Latency: one cycle from accept to `ex_valid`. Full throughput, one instruction per cycle, when unstalled.
- Simultaneous `ex_ready` and accept: the register reloads, ex_valid stays 1, and there is no bubble.
- Flush arriving in the same cycle as `inst_valid`: the instruction is not accepted, and fetch must re-present it or drop it.
- Reset asserted mid-stall or mid-backpressure: all state clears immediately.

## Configuration
- `ID_BYPASS_EN` defined: forwarding mux active; stall=0 always.
- `ID_BYPASS_EN` undefined: stall=1 on any EX or WB match, and operands come only from the regfile.
  - A dependent instruction therefore waits until neither match holds, typically 2 cycles behind its producer.
- `rs*_addr` and the match logic are identical in both builds.

## Structure
- Shared package `cpu_pkg` holds:
  - the `INST_ADD` code;
  - the inst_type one-hot constants;
  - RV opcode/funct constants;
  - a packed `id_ex_t` struct (type, opcode, op1, op2, rd_addr, rd_we, illegal).
- Sub-module `id_fwd_mux`: one instance per source operand. Performs the match and priority selection, and outputs data plus a match flag.

## Test plan
- Reset with `rst_n`=0 mid-transfer → all outputs 0, ex_valid=0 asynchronously, inst_ready=0.
- ADDI x1,x0,5 (0x00500093) → next cycle: ex_valid=1, inst_type=5'b00010, opcode 8'h11, op1=0, op2=5, rd_addr=1, rd_we=1. Immediate 0xFFF gives op2 = all-ones.
- ADDI x1,x0,5 then ADD x2,x1,x1 (0x00108133) back-to-back, ex_rd_data=5:
  - bypass build → no stall, op1=op2=5;
  - non-bypass build → inst_ready=0 while the match holds, then regfile values are used.
- Hold ex_ready=0 with ex_valid=1 for 3 cycles → inst_ready=0, outputs unchanged. Release → the next instruction loads in the same cycle.
- Assert flush with ex_valid=1 and inst_valid=1 → next cycle ex_valid=0 and no instruction is accepted.
- Instruction 0xFFFFFFFF → ex_illegal=1, opcode 0, rd_we=0. ADD with rd=x0 → rd_we=0, and a later rs1=x0 never stalls.
